// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the line window buffer and the convolution datapath.
package conv_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int KERNEL_SIZE = 3;
  localparam int WIN_TAPS = 9;
  localparam int WIN_TL = 0;
  localparam int WIN_C = 4;
  localparam int WIN_BR = 8;
endpackage

// File: rtl/line_window_buffer_line_delay.sv
// line_delay: DEPTH-deep delay line with enable, built as a circular buffer.
module line_delay #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  // The slot about to be overwritten holds the sample from DEPTH enables ago.
  assign o_q = r_mem[r_ptr];
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_ptr <= '0;
    else if (i_en) r_ptr <= (r_ptr == PW'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  always_ff @(posedge Clk)
    if (i_en) r_mem[r_ptr] <= i_d;
endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: raster pixel stream to 3x3 windows, one per interior pixel.
// Optional LWB_WINDOW_COUNT_EN adds a 16-bit per-frame window counter output.
module line_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         valid_in,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [WIN_TAPS*DATA_WIDTH-1:0] window_out,
  output logic                         valid_out,
  output logic                         frame_done
`ifdef LWB_WINDOW_COUNT_EN
  ,
  output logic [15:0]                  window_count
`endif
);
  logic [DATA_WIDTH-1:0] w_tap1, w_tap2;
  logic [DATA_WIDTH-1:0] r_win [WIN_TAPS];
  logic [11:0]           r_col, r_row;
  logic                  r_valid, r_done;
  logic                  w_last_col, w_last_row, w_win;

  line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_ld0 (
    .Clk(Clk), .Rst(Rst), .i_en(valid_in), .i_d(data_in), .o_q(w_tap1)
  );
  line_delay #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH)) u_ld1 (
    .Clk(Clk), .Rst(Rst), .i_en(valid_in), .i_d(w_tap1), .o_q(w_tap2)
  );

  assign w_last_col = r_col == 12'(IMG_WIDTH - 1);
  assign w_last_row = r_row == 12'(IMG_HEIGHT - 1);
  // Columns 0 and 1 are masked so windows never straddle a line boundary.
  assign w_win      = valid_in && r_row >= 12'd2 && r_col >= 12'd2;

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) r_win[k] <= '0;
    end else begin
      r_valid <= w_win;
      r_done  <= valid_in && w_last_col && w_last_row;
      if (valid_in) begin
        r_col <= w_last_col ? '0 : r_col + 1'b1;
        if (w_last_col) r_row <= w_last_row ? '0 : r_row + 1'b1;
        for (int r = 0; r < KERNEL_SIZE; r++)
          for (int c = 0; c < KERNEL_SIZE - 1; c++)
            r_win[KERNEL_SIZE*r+c] <= r_win[KERNEL_SIZE*r+c+1];
        r_win[WIN_TL+2] <= w_tap2;
        r_win[WIN_C+1]  <= w_tap1;
        r_win[WIN_BR]   <= data_in;
      end
    end

  for (genvar k = 0; k < WIN_TAPS; k++) begin : g_win
    assign window_out[DATA_WIDTH*k +: DATA_WIDTH] = r_win[k];
  end
  assign valid_out  = r_valid;
  assign frame_done = r_done;

`ifdef LWB_WINDOW_COUNT_EN
  logic [15:0] r_cnt;
  // Cleared one cycle after frame_done so the frame total is visible alongside it.
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) r_cnt <= '0;
    else r_cnt <= (r_done ? 16'd0 : r_cnt) + {15'd0, w_win};
  assign window_count = r_cnt;
`endif
endmodule

// File: tb/tb_line_window_buffer.sv
// tb_line_window_buffer: directed 4x4 frames checked against a frame-array window model.
module tb_line_window_buffer;
  localparam int W = 4;
  localparam int H = 4;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = '0;
  logic [71:0] window_out;
  logic        valid_out, frame_done;
`ifdef LWB_WINDOW_COUNT_EN
  logic [15:0] window_count;
  logic        wc_next;
`endif

  line_window_buffer #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .Clk(Clk), .Rst(Rst), .valid_in(valid_in), .data_in(data_in),
    .window_out(window_out), .valid_out(valid_out), .frame_done(frame_done)
`ifdef LWB_WINDOW_COUNT_EN
    , .window_count(window_count)
`endif
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_bad = 0;
  int img [H][W];
  int m_r, m_c, e_cnt;
  logic e_valid, e_done, e_known, prev_done, first_m;
  logic [71:0] e_win, m_first, done_win;
  logic [71:0] seg_q [$];

  localparam logic [71:0] F1_FIRST = {8'h0A,8'h09,8'h08,8'h06,8'h05,8'h04,8'h02,8'h01,8'h00};
  localparam logic [71:0] F1_LAST  = {8'h0F,8'h0E,8'h0D,8'h0B,8'h0A,8'h09,8'h07,8'h06,8'h05};
  localparam logic [71:0] F2_FIRST = {8'h1A,8'h19,8'h18,8'h16,8'h15,8'h14,8'h12,8'h11,8'h10};
  localparam logic [71:0] F3_FIRST = {8'h2A,8'h29,8'h28,8'h26,8'h25,8'h24,8'h22,8'h21,8'h20};

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_r = 0; m_c = 0; e_cnt = 0;
    e_valid = 0; e_done = 0; prev_done = 0; e_known = 1; e_win = '0;
`ifdef LWB_WINDOW_COUNT_EN
    wc_next = 0;
`endif
  endtask

  task automatic seg_start();
    seg_q = {};
    first_m = 1;
    m_first = '0;
    done_win = '0;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in = d;
    prev_done = e_done;
    e_valid = 0;
    e_done = 0;
    if (v) begin
      img[m_r][m_c] = int'(d);
      if (m_r >= 2 && m_c >= 2) begin
        e_valid = 1;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e_win[8*(3*i+j) +: 8] = 8'(img[m_r-2+i][m_c-2+j]);
        if (first_m) begin m_first = e_win; first_m = 0; end
      end
      e_known = e_valid;
      e_done = (m_r == H - 1) && (m_c == W - 1);
      m_c++;
      if (m_c == W) begin m_c = 0; m_r = (m_r + 1) % H; end
    end
    e_cnt = (prev_done ? 0 : e_cnt) + (e_valid ? 1 : 0);
    @(posedge Clk);
    #1;
    chk("valid_out", 72'(valid_out), 72'(e_valid));
    chk("frame_done", 72'(frame_done), 72'(e_done));
    if (e_known) chk("window_out", window_out, e_win);
    if (v && (d == 8'h08 || d == 8'h09 || d == 8'h0C || d == 8'h0D))
      chk("col_boundary", 72'(valid_out), 72'(0));
`ifdef LWB_WINDOW_COUNT_EN
    chk("window_count", 72'(window_count), 72'(e_cnt));
    if (wc_next) chk("wc_after_done", 72'(window_count), 72'(0));
    if (frame_done) chk("wc_at_done", 72'(window_count), 72'(4));
    wc_next = frame_done;
`endif
    if (valid_out) seg_q.push_back(window_out);
    if (frame_done) done_win = window_out;
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_valid", 72'(valid_out), 72'(0));
    chk("rst_done", 72'(frame_done), 72'(0));
    chk("rst_window", window_out, 72'(0));
    #10 Rst = 1'b1;

    seg_start();
    for (int p = 0; p < 16; p++) step(1'b1, 8'(p));
    step(1'b0, 8'h00);
    chk("f1_count", 72'(seg_q.size()), 72'(4));
    chk("f1_first", seg_q[0], F1_FIRST);
    chk("f1_last", seg_q[seg_q.size()-1], F1_LAST);
    chk("f1_done_win", done_win, F1_LAST);
    chk("model_first", m_first, F1_FIRST);

    seg_start();
    for (int p = 0; p < 16; p++) begin
      step(1'b1, 8'(p));
      step(1'b0, 8'hFF);
      chk("gap_no_pulse", 72'(valid_out), 72'(0));
    end
    chk("gap_count", 72'(seg_q.size()), 72'(4));
    chk("gap_first", seg_q[0], F1_FIRST);
    chk("gap_last", seg_q[seg_q.size()-1], F1_LAST);

    seg_start();
    for (int p = 0; p < 32; p++) step(1'b1, 8'(p));
    step(1'b0, 8'h00);
    chk("b2b_count", 72'(seg_q.size()), 72'(8));
    chk("b2b_f1_first", seg_q[0], F1_FIRST);
    chk("b2b_f2_first", seg_q[4], F2_FIRST);
    chk("model_b2b_first", m_first, F1_FIRST);

    seg_start();
    for (int p = 0; p < 10; p++) step(1'b1, 8'(p));
    valid_in = 1'b0;
    #2 Rst = 1'b0;
    #1;
    chk("midrst_valid", 72'(valid_out), 72'(0));
    chk("midrst_done", 72'(frame_done), 72'(0));
    chk("midrst_window", window_out, 72'(0));
    model_reset();
    #10 Rst = 1'b1;
    seg_start();
    for (int p = 32; p < 48; p++) step(1'b1, 8'(p));
    step(1'b0, 8'h00);
    chk("f3_count", 72'(seg_q.size()), 72'(4));
    chk("f3_first", seg_q[0], F3_FIRST);
    chk("model_f3_first", m_first, F3_FIRST);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
